// File: rtl/ecc_pkg.sv
// Shared types for the elliptic-curve point sequencer: GFAU op codes, FSM states,
// register indices and the microcode step format.
package ecc_pkg;

  typedef enum logic [1:0] {
    OpAdd = 2'd0,
    OpSub = 2'd1,
    OpMul = 2'd2,
    OpDiv = 2'd3
  } gfau_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  typedef logic [2:0] reg_idx_t;

  localparam reg_idx_t RegX1 = 3'd0;
  localparam reg_idx_t RegY1 = 3'd1;
  localparam reg_idx_t RegX2 = 3'd2;
  localparam reg_idx_t RegY2 = 3'd3;
  localparam reg_idx_t RegA  = 3'd4;
  localparam reg_idx_t RegT5 = 3'd5;
  localparam reg_idx_t RegT6 = 3'd6;
  localparam reg_idx_t RegT7 = 3'd7;

  localparam int unsigned DBL_STEPS = 12;
  localparam int unsigned ADD_STEPS = 9;
  localparam int unsigned PcW       = 4;

  typedef logic [PcW-1:0] pc_t;

  typedef struct packed {
    gfau_op_e op;
    reg_idx_t src_a;
    reg_idx_t src_b;
    reg_idx_t dst;
    logic     last;
  } step_t;

  function automatic step_t mk_step(gfau_op_e op, reg_idx_t a, reg_idx_t b, reg_idx_t d);
    mk_step = '{op: op, src_a: a, src_b: b, dst: d, last: 1'b0};
  endfunction

endpackage

// File: rtl/ecc_point_seq_if.sv
// Bundles the controller-facing and GFAU-facing signals of the point sequencer.
interface ecc_point_seq_if #(
  parameter int unsigned SIZE = 32
);
  logic            start;
  logic            mode;
  logic [SIZE-1:0] x1;
  logic [SIZE-1:0] y1;
  logic [SIZE-1:0] x2;
  logic [SIZE-1:0] y2;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] prime;
  logic            busy;
  logic            done;
  logic            err;
  logic [SIZE-1:0] x3;
  logic [SIZE-1:0] y3;
  logic [SIZE-1:0] gfau_in_0;
  logic [SIZE-1:0] gfau_in_1;
  logic [SIZE-1:0] gfau_prime;
  logic [1:0]      gfau_op;
  logic            gfau_go;
  logic            gfau_done;
  logic [SIZE-1:0] gfau_result;

  // Environment side: scalar-mult controller plus the GFAU.
  modport master (
    output start, mode, x1, y1, x2, y2, a, prime, gfau_done, gfau_result,
    input  busy, done, err, x3, y3, gfau_in_0, gfau_in_1, gfau_prime, gfau_op, gfau_go
  );

  modport slave (
    input  start, mode, x1, y1, x2, y2, a, prime, gfau_done, gfau_result,
    output busy, done, err, x3, y3, gfau_in_0, gfau_in_1, gfau_prime, gfau_op, gfau_go
  );
endinterface

// File: rtl/ecc_ucode_rom.sv
// Step ROM: maps (mode, pc) to one GFAU operation of the affine double/add recipe.
module ecc_ucode_rom
  import ecc_pkg::*;
(
  input  logic  mode,
  input  pc_t   pc,
  output step_t step
);

  always_comb begin
    step = mk_step(OpAdd, RegX1, RegX1, RegX1);
    if (!mode) begin
      case (pc)
        4'd0:    step = mk_step(OpMul, RegX1, RegX1, RegT5);
        4'd1:    step = mk_step(OpAdd, RegT5, RegT5, RegT6);
        4'd2:    step = mk_step(OpAdd, RegT6, RegT5, RegT5);
        4'd3:    step = mk_step(OpAdd, RegT5, RegA,  RegT5);
        4'd4:    step = mk_step(OpAdd, RegY1, RegY1, RegT6);
        4'd5:    step = mk_step(OpDiv, RegT5, RegT6, RegT5);
        4'd6:    step = mk_step(OpMul, RegT5, RegT5, RegT6);
        4'd7:    step = mk_step(OpSub, RegT6, RegX1, RegT6);
        4'd8:    step = mk_step(OpSub, RegT6, RegX1, RegT6);
        4'd9:    step = mk_step(OpSub, RegX1, RegT6, RegT7);
        4'd10:   step = mk_step(OpMul, RegT5, RegT7, RegT7);
        4'd11:   step = mk_step(OpSub, RegT7, RegY1, RegT7);
        default: ;
      endcase
      step.last = (pc == PcW'(DBL_STEPS - 1));
    end else begin
      case (pc)
        4'd0:    step = mk_step(OpSub, RegY2, RegY1, RegT5);
        4'd1:    step = mk_step(OpSub, RegX2, RegX1, RegT6);
        4'd2:    step = mk_step(OpDiv, RegT5, RegT6, RegT5);
        4'd3:    step = mk_step(OpMul, RegT5, RegT5, RegT6);
        4'd4:    step = mk_step(OpSub, RegT6, RegX1, RegT6);
        4'd5:    step = mk_step(OpSub, RegT6, RegX2, RegT6);
        4'd6:    step = mk_step(OpSub, RegX1, RegT6, RegT7);
        4'd7:    step = mk_step(OpMul, RegT5, RegT7, RegT7);
        4'd8:    step = mk_step(OpSub, RegT7, RegY1, RegT7);
        default: ;
      endcase
      step.last = (pc == PcW'(ADD_STEPS - 1));
    end
  end

endmodule

// File: rtl/ecc_point_seq.sv
// Point double/add sequencer: walks the step ROM, issuing one GFAU op at a time and
// writing results back into an 8-entry register file.
module ecc_point_seq
  import ecc_pkg::*;
#(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned L_MAX = 64
) (
  input logic          i_clk,
  input logic          i_rst_n,
  ecc_point_seq_if.slave bus
);

  localparam int unsigned WdW = $clog2(L_MAX + 1);

  state_e          state_q, state_d;
  pc_t             pc_q, pc_d;
  logic            mode_q, mode_d;
  logic [SIZE-1:0] rf_q [8];
  logic [SIZE-1:0] rf_d [8];
  logic [SIZE-1:0] prime_q, prime_d;
  logic [WdW-1:0]  wd_q, wd_d;
  logic            err_q, err_d;
  logic [SIZE-1:0] x3_q, x3_d;
  logic [SIZE-1:0] y3_q, y3_d;
  logic            go;
  logic            active;
  step_t           step;

  ecc_ucode_rom u_rom (
    .mode (mode_q),
    .pc   (pc_q),
    .step (step)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mode_d  = mode_q;
    rf_d    = rf_q;
    prime_d = prime_q;
    wd_d    = wd_q;
    err_d   = err_q;
    x3_d    = x3_q;
    y3_d    = y3_q;
    go      = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d      = StIssue;
          pc_d         = '0;
          mode_d       = bus.mode;
          rf_d[RegX1]  = bus.x1;
          rf_d[RegY1]  = bus.y1;
          rf_d[RegX2]  = bus.x2;
          rf_d[RegY2]  = bus.y2;
          rf_d[RegA]   = bus.a;
          prime_d      = bus.prime;
          err_d        = 1'b0;
        end
      end
      StIssue: begin
        // A zero divisor means the result is the point at infinity; never hand it to the GFAU.
        if (step.op == OpDiv && rf_q[step.src_b] == '0) begin
          err_d   = 1'b1;
          x3_d    = '0;
          y3_d    = '0;
          state_d = StDone;
        end else begin
          go      = 1'b1;
          wd_d    = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.gfau_done) begin
          rf_d[step.dst] = bus.gfau_result;
          if (step.last) begin
            x3_d    = rf_d[RegT6];
            y3_d    = rf_d[RegT7];
            state_d = StDone;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = StIssue;
          end
        end else if (wd_q == WdW'(L_MAX - 1)) begin
          err_d   = 1'b1;
          x3_d    = '0;
          y3_d    = '0;
          state_d = StDone;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      mode_q  <= 1'b0;
      prime_q <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      x3_q    <= '0;
      y3_q    <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mode_q  <= mode_d;
      prime_q <= prime_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      x3_q    <= x3_d;
      y3_q    <= y3_d;
      rf_q    <= rf_d;
    end
  end

  // pc and regfile are frozen while waiting, so the operands stay stable without extra flops.
  assign active         = (state_q == StIssue) || (state_q == StWait);
  assign bus.gfau_op    = active ? step.op : 2'd0;
  assign bus.gfau_in_0  = active ? rf_q[step.src_a] : '0;
  assign bus.gfau_in_1  = active ? rf_q[step.src_b] : '0;
  assign bus.gfau_prime = prime_q;
  assign bus.gfau_go    = go;
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StDone);
  assign bus.err        = err_q;
  assign bus.x3         = x3_q;
  assign bus.y3         = y3_q;

endmodule

// File: tb/tb_ecc_point_seq.sv
// Directed bench for ecc_point_seq on y^2 = x^3 + 2x + 3 over GF(97), with a
// behavioural GFAU whose latency varies per operation.
module tb_ecc_point_seq;

  localparam int unsigned Size   = 32;
  localparam int unsigned LMax   = 64;
  localparam int          MaxCyc = 500;

  logic clk;
  logic rst_n;
  logic silent;
  logic stray_done;
  logic m_done;
  logic [Size-1:0] m_result;
  int   go_cnt;
  int   lk_sum;
  int   n_checks;
  int   n_fail;

  ecc_point_seq_if #(.SIZE(Size)) bus ();

  ecc_point_seq #(
    .SIZE  (Size),
    .L_MAX (LMax)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  assign bus.gfau_done   = m_done | stray_done;
  assign bus.gfau_result = m_result;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [Size-1:0] gfau_fn(input logic [1:0] op, input logic [Size-1:0] a,
                                              input logic [Size-1:0] b, input logic [Size-1:0] p);
    logic [63:0] aa, bb, pp, r, base, e;
    aa = 64'(a);
    bb = 64'(b);
    pp = 64'(p);
    case (op)
      2'd0:    r = (aa + bb) % pp;
      2'd1:    r = (aa + pp - bb) % pp;
      2'd2:    r = (aa * bb) % pp;
      default: begin
        r    = 64'd1;
        base = bb % pp;
        e    = pp - 64'd2;
        while (e != 0) begin
          if (e[0]) r = (r * base) % pp;
          base = (base * base) % pp;
          e    = e >> 1;
        end
        r = (aa * r) % pp;
      end
    endcase
    return r[Size-1:0];
  endfunction

  // GFAU model: sees go mid-cycle, answers Lk cycles later unless silenced or reset.
  initial begin : gfau_model
    int lk;
    logic [Size-1:0] res;
    logic live;
    m_done   = 1'b0;
    m_result = '0;
    go_cnt   = 0;
    lk_sum   = 0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.gfau_go) begin
        go_cnt++;
        lk     = int'($urandom_range(8, 1));
        lk_sum += lk;
        res    = gfau_fn(bus.gfau_op, bus.gfau_in_0, bus.gfau_in_1, bus.gfau_prime);
        if (!silent) begin
          live = 1'b1;
          for (int i = 0; i < lk; i++) begin
            @(posedge clk);
            if (!rst_n) live = 1'b0;
          end
          if (live) begin
            #1;
            m_result = res;
            m_done   = 1'b1;
            @(posedge clk);
            #1;
            m_done = 1'b0;
          end
        end
      end
    end
  end

  task automatic run_op(input logic m, input logic [Size-1:0] x1, input logic [Size-1:0] y1,
                        input logic [Size-1:0] x2, input logic [Size-1:0] y2, input int poke,
                        output int lat, output int gos, output int lks, output logic err,
                        output logic [Size-1:0] x3, output logic [Size-1:0] y3,
                        output logic busy_after);
    int g0, l0, n;
    logic seen;
    @(negedge clk);
    bus.mode  = m;
    bus.x1    = x1;
    bus.y1    = y1;
    bus.x2    = x2;
    bus.y2    = y2;
    bus.start = 1'b1;
    g0 = go_cnt;
    l0 = lk_sum;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n    = 0;
    seen = 1'b0;
    lat  = -1;
    err  = 1'b0;
    x3   = '0;
    y3   = '0;
    while (!seen && n < MaxCyc) begin
      @(posedge clk);
      #1;
      n++;
      if (poke > 0 && n == poke + 1) begin
        bus.start = 1'b0;
        bus.mode  = m;
        bus.x1    = x1;
      end
      if (poke > 0 && n == poke) begin
        bus.start = 1'b1;
        bus.mode  = !m;
        bus.x1    = 32'd11;
      end
      if (bus.done) begin
        seen = 1'b1;
        lat  = n + 1;
        err  = bus.err;
        x3   = bus.x3;
        y3   = bus.y3;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    gos = go_cnt - g0;
    lks = lk_sum - l0;
    @(posedge clk);
    #1;
    busy_after = bus.busy;
  endtask

  int lat, gos, lks, g0, k;
  logic err, busy_after;
  logic [Size-1:0] x3, y3;

  initial begin
    clk        = 1'b0;
    rst_n      = 1'b0;
    silent     = 1'b0;
    stray_done = 1'b0;
    n_checks   = 0;
    n_fail     = 0;
    bus.start  = 1'b0;
    bus.mode   = 1'b0;
    bus.x1     = '0;
    bus.y1     = '0;
    bus.x2     = '0;
    bus.y2     = '0;
    bus.a      = 32'd2;
    bus.prime  = 32'd97;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_go", 64'(bus.gfau_go), 64'd0);
    check("rst_x3", 64'(bus.x3), 64'd0);
    check("rst_op", 64'(bus.gfau_op), 64'd0);
    check("rst_in0", 64'(bus.gfau_in_0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2*(3,6) = (80,10)
    run_op(1'b0, 32'd3, 32'd6, 32'd0, 32'd0, 0, lat, gos, lks, err, x3, y3, busy_after);
    check("dbl_x3", 64'(x3), 64'd80);
    check("dbl_y3", 64'(y3), 64'd10);
    check("dbl_err", 64'(err), 64'd0);
    check("dbl_gos", 64'(gos), 64'd12);
    check("dbl_lat", 64'(lat), 64'(1 + gos + lks));
    check("dbl_busy_fall", 64'(busy_after), 64'd0);

    // A GFAU done outside WAIT must not start or disturb anything.
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    check("stray_busy", 64'(bus.busy), 64'd0);
    check("stray_x3", 64'(bus.x3), 64'd80);

    // (3,6)+(80,10) = (80,87)
    run_op(1'b1, 32'd3, 32'd6, 32'd80, 32'd10, 0, lat, gos, lks, err, x3, y3, busy_after);
    check("add_x3", 64'(x3), 64'd80);
    check("add_y3", 64'(y3), 64'd87);
    check("add_err", 64'(err), 64'd0);
    check("add_gos", 64'(gos), 64'd9);
    check("add_lat", 64'(lat), 64'(1 + gos + lks));

    // (3,6)+(3,91): x2-x1 = 0 at the divide
    run_op(1'b1, 32'd3, 32'd6, 32'd3, 32'd91, 0, lat, gos, lks, err, x3, y3, busy_after);
    check("inf_add_err", 64'(err), 64'd1);
    check("inf_add_x3", 64'(x3), 64'd0);
    check("inf_add_y3", 64'(y3), 64'd0);
    check("inf_add_gos", 64'(gos), 64'd2);

    // 2*(5,0): 2*y1 = 0 at the divide
    run_op(1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 0, lat, gos, lks, err, x3, y3, busy_after);
    check("inf_dbl_err", 64'(err), 64'd1);
    check("inf_dbl_gos", 64'(gos), 64'd5);

    // Start pulsed mid-operation with different mode/x1 is ignored.
    run_op(1'b0, 32'd3, 32'd6, 32'd0, 32'd0, 7, lat, gos, lks, err, x3, y3, busy_after);
    check("poke_x3", 64'(x3), 64'd80);
    check("poke_y3", 64'(y3), 64'd10);
    check("poke_err", 64'(err), 64'd0);
    check("poke_gos", 64'(gos), 64'd12);
    check("poke_busy_fall", 64'(busy_after), 64'd0);

    // Reset while waiting on the fifth GFAU op.
    @(negedge clk);
    bus.mode  = 1'b0;
    bus.x1    = 32'd3;
    bus.y1    = 32'd6;
    bus.start = 1'b1;
    g0 = go_cnt;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    k = 0;
    while (go_cnt - g0 < 5 && k < MaxCyc) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("mid_reach_step5", 64'(go_cnt - g0), 64'd5);
    check("mid_busy_pre", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", 64'(bus.busy), 64'd0);
    check("mid_done", 64'(bus.done), 64'd0);
    check("mid_x3", 64'(bus.x3), 64'd0);
    check("mid_y3", 64'(bus.y3), 64'd0);
    check("mid_in0", 64'(bus.gfau_in_0), 64'd0);
    check("mid_in1", 64'(bus.gfau_in_1), 64'd0);
    check("mid_prime", 64'(bus.gfau_prime), 64'd0);
    check("mid_op", 64'(bus.gfau_op), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("mid_idle_after", 64'(bus.busy), 64'd0);

    // Silent GFAU: watchdog expires L_MAX cycles after the go.
    silent = 1'b1;
    run_op(1'b0, 32'd3, 32'd6, 32'd0, 32'd0, 0, lat, gos, lks, err, x3, y3, busy_after);
    silent = 1'b0;
    check("wd_err", 64'(err), 64'd1);
    check("wd_gos", 64'(gos), 64'd1);
    check("wd_lat", 64'(lat), 64'(LMax + 2));
    check("wd_x3", 64'(x3), 64'd0);

    // Recovery: normal add straight after the watchdog error.
    run_op(1'b1, 32'd3, 32'd6, 32'd80, 32'd10, 0, lat, gos, lks, err, x3, y3, busy_after);
    check("rec_x3", 64'(x3), 64'd80);
    check("rec_y3", 64'(y3), 64'd87);
    check("rec_err", 64'(err), 64'd0);
    check("rec_lat", 64'(lat), 64'(1 + gos + lks));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
